// File: rtl/f1_ibuff_pkg.sv
// Shared frontend constants and types for the fetch instruction buffer.
// Holds line geometry, the buffered entry type and RVC parcel helpers.
package f1_ibuff_pkg;

   localparam int LINE_BYTES   = 64;
   localparam int LINE_W       = 512;
   localparam int OFFSET_W     = 6;
   localparam int PARCEL_BYTES = 2;
   localparam int PARCEL_W     = 16;
   localparam int INSN_BYTES   = 4;
   localparam logic [1:0] RVC_FULL_OPC = 2'b11;

   typedef struct packed {
      logic [LINE_W-1:0] line;
      logic              exception;
   } ibuff_entry_t;

   // A parcel whose low two bits are 2'b11 starts a 4-byte instruction.
   function automatic logic isFullWidth(input logic [1:0] lowBits);
      return lowBits == RVC_FULL_OPC;
   endfunction

endpackage

// File: rtl/f1_ibuff_fifo.sv
// Circular line store for the instruction buffer: storage, head/tail pointers
// and occupancy count. Line data is not reset; exception bits are.
module f1_ibuff_fifo
   import f1_ibuff_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              push_i,
   input  ibuff_entry_t      entry_i,
   input  logic              pop_i,
   output ibuff_entry_t      head_o,
   output logic [LINE_W-1:0] nextLine_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [LINE_W-1:0] lineMem [DEPTH];
   logic [DEPTH-1:0]  excMem_q;
   logic [PTR_W-1:0]  headPtr_q, headPtr_d;
   logic [PTR_W-1:0]  tailPtr_q, tailPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  nextPtr;

   always_ff @(posedge clk) begin
      if (push_i) begin
         lineMem[tailPtr_q] <= entry_i.line;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         excMem_q <= '0;
      end else if (push_i) begin
         excMem_q[tailPtr_q] <= entry_i.exception;
      end
   end

   // Flush rewinds both pointers so the next line lands in entry 0.
   always_comb begin
      headPtr_d = headPtr_q + PTR_W'(pop_i);
      tailPtr_d = tailPtr_q + PTR_W'(push_i);
      count_d   = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      if (flush_i) begin
         headPtr_d = '0;
         tailPtr_d = '0;
         count_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         headPtr_q <= '0;
         tailPtr_q <= '0;
         count_q   <= '0;
      end else begin
         headPtr_q <= headPtr_d;
         tailPtr_q <= tailPtr_d;
         count_q   <= count_d;
      end
   end

   assign nextPtr          = headPtr_q + PTR_W'(1);
   assign head_o.line      = lineMem[headPtr_q];
   assign head_o.exception = excMem_q[headPtr_q];
   assign nextLine_o       = lineMem[nextPtr];
   assign count_o          = count_q;

endmodule

// File: rtl/f1_ibuff.sv
// Fetch instruction buffer between I$ and D1: queues 64-byte lines, tracks the
// decode PC and stitches 4-byte instructions that straddle two lines.
// Optional empty-bypass path enabled by defining IBUFF_BYPASS_EN.
module f1_ibuff
   import f1_ibuff_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [LINE_W-1:0] in_line,
   input  logic              in_exception,
   output logic              in_ready,
   input  logic              resteer,
   input  logic [31:0]       resteer_target,
   input  logic              adv,
   input  logic              adv_size,
   output logic              out_valid,
   output logic [LINE_W-1:0] out_line,
   output logic [31:0]       out_pc,
   output logic              out_exception,
   output logic              out_straddle
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [OFFSET_W-1:0] LAST_PARCEL = OFFSET_W'(LINE_BYTES - PARCEL_BYTES);

   ibuff_entry_t      headEntry, inEntry, curEntry;
   logic [LINE_W-1:0] nextLine;
   logic [CNT_W-1:0]  count;
   logic [31:0]       pc_q, pc_d;
   logic [OFFSET_W-1:0] offset;
   logic [OFFSET_W:0] endOffset;
   logic              hasHead, curValid, headExc, straddle, haveBytes;
   logic              advOk, advPop, pushReq, fifoPush, fifoPop;
`ifdef IBUFF_BYPASS_EN
   logic              bypassActive;
`endif

   assign inEntry.line      = in_line;
   assign inEntry.exception = in_exception;
   assign offset            = pc_q[OFFSET_W-1:0];
   assign hasHead           = (count != '0);

   // Select the line D1 sees; with bypass an empty buffer exposes the I$ line.
   always_comb begin
      curEntry = headEntry;
      curValid = hasHead;
`ifdef IBUFF_BYPASS_EN
      bypassActive = 1'b0;
      if (!hasHead && in_valid && !resteer) begin
         curEntry     = inEntry;
         curValid     = 1'b1;
         bypassActive = 1'b1;
      end
`endif
   end

   // A faulted head is always presented so D1 can raise the exception.
   always_comb begin
      headExc   = curValid && curEntry.exception;
      straddle  = !headExc && curValid && (offset == LAST_PARCEL) &&
                  isFullWidth(curEntry.line[(LINE_BYTES-PARCEL_BYTES)*8 +: 2]);
      haveBytes = straddle ? (count >= CNT_W'(2)) : curValid;
      out_valid     = headExc || haveBytes;
      out_straddle  = straddle && haveBytes;
      out_exception = headExc;
      out_line      = curEntry.line;
      if (out_straddle) begin
         out_line[PARCEL_W-1:0] = nextLine[PARCEL_W-1:0];
      end
   end

   assign out_pc   = pc_q;
   assign in_ready = (count < CNT_W'(DEPTH));

   always_comb begin
      advOk     = adv && out_valid && !headExc;
      endOffset = {1'b0, offset} + (adv_size ? (OFFSET_W+1)'(INSN_BYTES)
                                             : (OFFSET_W+1)'(PARCEL_BYTES));
      advPop    = advOk && endOffset[OFFSET_W];
      pushReq   = in_valid && in_ready && !resteer;
      fifoPush  = pushReq;
`ifdef IBUFF_BYPASS_EN
      if (bypassActive && advPop) begin
         fifoPush = 1'b0;
      end
`endif
      fifoPop   = advPop && hasHead && !resteer;
   end

   always_comb begin
      pc_d = pc_q;
      if (resteer) begin
         pc_d = resteer_target;
      end else if (advOk) begin
         pc_d = pc_q + (adv_size ? 32'd4 : 32'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   f1_ibuff_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (resteer),
      .push_i     (fifoPush),
      .entry_i    (inEntry),
      .pop_i      (fifoPop),
      .head_o     (headEntry),
      .nextLine_o (nextLine),
      .count_o    (count)
   );

endmodule

// File: tb/tb_f1_ibuff.sv
// Directed self-checking bench for f1_ibuff (DEPTH 4, RESET_PC 0x1000).
// Build with IBUFF_BYPASS_EN to exercise the empty-bypass variant.
module tb_f1_ibuff;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [511:0] in_line = '0;
   logic         in_exception = 1'b0;
   logic         in_ready;
   logic         resteer = 1'b0;
   logic [31:0]  resteer_target = '0;
   logic         adv = 1'b0;
   logic         adv_size = 1'b0;
   logic         out_valid;
   logic [511:0] out_line;
   logic [31:0]  out_pc;
   logic         out_exception;
   logic         out_straddle;

   int passCount = 0;
   int failCount = 0;
   int checkCount = 0;

   logic [511:0] lineA, lineB, lineC, lineD, lineE, lineF, lineG, lineH, lineX, lineW;
   logic [511:0] stitched;

   f1_ibuff #(.DEPTH(4), .RESET_PC(32'h0000_1000)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_line        (in_line),
      .in_exception   (in_exception),
      .in_ready       (in_ready),
      .resteer        (resteer),
      .resteer_target (resteer_target),
      .adv            (adv),
      .adv_size       (adv_size),
      .out_valid      (out_valid),
      .out_line       (out_line),
      .out_pc         (out_pc),
      .out_exception  (out_exception),
      .out_straddle   (out_straddle)
   );

   always #5 clk = ~clk;

   // Line whose byte k is seed+k, with byte 62 forced to b62.
   function automatic logic [511:0] mkLine(input logic [7:0] seed, input logic [7:0] b62);
      logic [511:0] l;
      for (int k = 0; k < 64; k++) l[8*k +: 8] = seed + 8'(k);
      l[62*8 +: 8] = b62;
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [511:0] ln, input logic exc,
                                input logic rs, input logic [31:0] tgt,
                                input logic a, input logic asz);
      in_valid = v; in_line = ln; in_exception = exc;
      resteer = rs; resteer_target = tgt; adv = a; adv_size = asz;
      tick();
      in_valid = 1'b0; in_exception = 1'b0; resteer = 1'b0; adv = 1'b0; adv_size = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      lineA = mkLine(8'h10, 8'h00);
      lineB = mkLine(8'h20, 8'h00);
      lineC = mkLine(8'h30, 8'h00);
      lineD = mkLine(8'h40, 8'h00);
      lineE = mkLine(8'h60, 8'h00);
      lineF = mkLine(8'h70, 8'h00);
      lineG = mkLine(8'h50, 8'h13);
      lineH = mkLine(8'hA0, 8'h00);
      lineX = mkLine(8'hC0, 8'h00);
      lineW = mkLine(8'hE0, 8'h00);

      // Reset state
      tick(); tick();
      rst = 1'b1;
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_exc", out_exception, 0);
      checkOutput("rst_straddle", out_straddle, 0);
      checkOutput("rst_pc", out_pc, 32'h1000);
      checkOutput("rst_ready", in_ready, 1);

      // First push: visible next cycle (or same cycle with bypass)
      in_valid = 1'b1; in_line = lineA;
      #1;
`ifdef IBUFF_BYPASS_EN
      checkOutput("bypass_valid", out_valid, 1);
      checkOutput("bypass_line", out_line, lineA);
`else
      checkOutput("no_bypass_valid", out_valid, 0);
`endif
      applyStimulus(1, lineA, 0, 0, 0, 0, 0);
      checkOutput("push1_valid", out_valid, 1);
      checkOutput("push1_pc", out_pc, 32'h1000);
      checkOutput("push1_ready", in_ready, 1);
      checkOutput("push1_line", out_line, lineA);

      // Fill to DEPTH, fifth line dropped
      applyStimulus(1, lineB, 0, 0, 0, 0, 0);
      applyStimulus(1, lineC, 0, 0, 0, 0, 0);
      applyStimulus(1, lineD, 0, 0, 0, 0, 0);
      checkOutput("full_ready", in_ready, 0);
      applyStimulus(1, lineE, 0, 0, 0, 0, 0);
      checkOutput("full_head", out_line, lineA);

      // 16 four-byte advances consume line A exactly
      for (int i = 0; i < 16; i++) applyStimulus(0, '0, 0, 0, 0, 1, 1);
      checkOutput("adv16_pc", out_pc, 32'h1040);
      checkOutput("adv16_head", out_line, lineB);
      checkOutput("adv16_ready", in_ready, 1);
      applyStimulus(1, lineF, 0, 0, 0, 0, 0);
      checkOutput("refill_ready", in_ready, 0);

      // Straddling 4-byte instruction at offset 62
      applyStimulus(0, '0, 0, 1, 32'h103E, 0, 0);
      checkOutput("rs_pc", out_pc, 32'h103E);
      checkOutput("rs_valid", out_valid, 0);
      applyStimulus(1, lineG, 0, 0, 0, 0, 0);
      checkOutput("strad_wait_valid", out_valid, 0);
      checkOutput("strad_wait_flag", out_straddle, 0);
      applyStimulus(1, lineH, 0, 0, 0, 0, 0);
      checkOutput("strad_flag", out_straddle, 1);
      checkOutput("strad_valid", out_valid, 1);
      checkOutput("strad_low", out_line[15:0], 16'hA1A0);
      stitched = lineG;
      stitched[15:0] = 16'hA1A0;
      checkOutput("strad_line", out_line, stitched);
      applyStimulus(0, '0, 0, 0, 0, 1, 1);
      checkOutput("strad_adv_pc", out_pc, 32'h1042);
      checkOutput("strad_adv_line", out_line, lineH);
      checkOutput("strad_adv_valid", out_valid, 1);

      // Faulted head blocks advance until resteer
      applyStimulus(0, '0, 0, 1, 32'h3000, 0, 0);
      applyStimulus(1, lineX, 1, 0, 0, 0, 0);
      checkOutput("exc_flag", out_exception, 1);
      checkOutput("exc_valid", out_valid, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, 0, 0, 1, 1);
      checkOutput("exc_pc", out_pc, 32'h3000);
      checkOutput("exc_hold", out_exception, 1);
      applyStimulus(0, '0, 0, 1, 32'h2000, 0, 0);
      checkOutput("exc_rs_pc", out_pc, 32'h2000);
      checkOutput("exc_rs_valid", out_valid, 0);
      checkOutput("exc_rs_flag", out_exception, 0);

      // Resteer beats simultaneous push and advance
      applyStimulus(1, lineA, 0, 0, 0, 0, 0);
      applyStimulus(1, lineB, 0, 0, 0, 0, 0);
      applyStimulus(1, lineC, 0, 1, 32'h4000, 1, 1);
      checkOutput("prio_pc", out_pc, 32'h4000);
      checkOutput("prio_valid", out_valid, 0);
      checkOutput("prio_ready", in_ready, 1);
      applyStimulus(0, '0, 0, 0, 0, 1, 1);
      checkOutput("idle_adv_pc", out_pc, 32'h4000);
      checkOutput("idle_valid", out_valid, 0);

      // Two-byte advance wraps PC and pops at offset 62
      applyStimulus(0, '0, 0, 1, 32'hFFFF_FFFE, 0, 0);
      applyStimulus(1, lineW, 0, 0, 0, 0, 0);
      checkOutput("wrap_valid_pre", out_valid, 1);
      checkOutput("wrap_strad_pre", out_straddle, 0);
      applyStimulus(0, '0, 0, 0, 0, 1, 0);
      checkOutput("wrap_pc", out_pc, 32'h0000_0000);
      checkOutput("wrap_valid", out_valid, 0);

      // Reset mid-operation overrides resteer and push
      applyStimulus(1, lineA, 0, 0, 0, 0, 0);
      rst = 1'b0;
      applyStimulus(1, lineB, 0, 1, 32'h5555, 1, 1);
      rst = 1'b1;
      checkOutput("mrst_pc", out_pc, 32'h1000);
      checkOutput("mrst_valid", out_valid, 0);
      checkOutput("mrst_ready", in_ready, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
